// File: rtl/ms_interval_meter.sv
// ---------------------------------------------------------------------------
// ms_interval_meter
//
// Measures the time between a start pulse and a stop pulse in whole
// milliseconds. It runs on the system clock and sits beside the ms tick timer.
// The captured result feeds the display and reaction-time logic.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   start    in   1  sync pulse; begins a measurement (from IDLE or DONE)
//   stop     in   1  sync pulse; ends a measurement (RUN only)
//   clear    in   1  sync; aborts and zeroes everything, highest priority
//   ms_live  out  W  running ms count (the ms counter register)
//   result   out  W  captured interval in ms
//   valid    out  1  result holds a completed measurement
//   busy     out  1  measurement in progress (decode of the state register)
//   ovf      out  1  sticky; ms counter ran past 2^W-1 in this measurement
//
// Configuration
//   MS_METER_SAT_EN  defined   : ms counter saturates at 2^W-1 on overflow
//                    undefined : ms counter wraps to 0 (result modulo 2^W)
//   ovf behaves the same way in both builds.
// ---------------------------------------------------------------------------
module ms_interval_meter #(
    parameter int CYCLES_PER_MS = 100000,
    parameter int W             = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    output logic [W-1:0] ms_live,
    output logic [W-1:0] result,
    output logic         valid,
    output logic         busy,
    output logic         ovf
);

    localparam int PW = $clog2(CYCLES_PER_MS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [W-1:0]  MS_MAX     = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [W-1:0]  ms_cnt;

    logic          tick;
    logic [PW-1:0] presc_next;
    logic [W-1:0]  ms_next;
    logic          ovf_next;

    // Advance the ms counter by one; the overflow policy lives here.
    function automatic logic [W-1:0] ms_step(input logic [W-1:0] cnt);
`ifdef MS_METER_SAT_EN
        return (cnt == MS_MAX) ? cnt : cnt + W'(1);
`else
        return cnt + W'(1);
`endif
    endfunction

    // Next-count values while running. The stop edge uses the same values,
    // so a capture includes the ms increment that falls due on that edge.
    always_comb begin
        tick       = (presc == PRESC_LAST);
        presc_next = tick ? '0 : presc + PW'(1);
        ms_next    = tick ? ms_step(ms_cnt) : ms_cnt;
        ovf_next   = ovf | (tick & (ms_cnt == MS_MAX));
    end

    // Control FSM plus counters. The priority is clear > stop > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= '0;
            ms_cnt <= '0;
            result <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            presc  <= '0;
            ms_cnt <= '0;
            result <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // stop is ignored here, even together with start
                    if (start) begin
                        state  <= RUN;
                        presc  <= '0;
                        ms_cnt <= '0;
                        ovf    <= 1'b0;
                        valid  <= 1'b0;
                    end
                end
                RUN: begin
                    presc  <= presc_next;
                    ms_cnt <= ms_next;
                    ovf    <= ovf_next;
                    // start is ignored while running; start+stop acts as stop
                    if (stop) begin
                        state  <= DONE;
                        result <= ms_next;
                        valid  <= 1'b1;
                    end
                end
                DONE: begin
                    // result stays at the previous capture until the next stop
                    if (start) begin
                        state  <= RUN;
                        presc  <= '0;
                        ms_cnt <= '0;
                        ovf    <= 1'b0;
                        valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ms_live = ms_cnt;
    assign busy    = (state == RUN);

endmodule

// File: tb/tb_ms_interval_meter.sv
module tb_ms_interval_meter;

    localparam int CPM = 10;
    localparam int W   = 4;

`ifdef MS_METER_SAT_EN
    localparam int OVF_RESULT = 15;
`else
    localparam int OVF_RESULT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         clear;
    logic [W-1:0] ms_live;
    logic [W-1:0] result;
    logic         valid;
    logic         busy;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    ms_interval_meter #(
        .CYCLES_PER_MS (CPM),
        .W             (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .ms_live (ms_live),
        .result  (result),
        .valid   (valid),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait n rising edges, then step 1 ns past the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present start/stop for exactly one sampling edge.
    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ms_live"}, int'(ms_live), 0);
        check({tag, "_result"},  int'(result),  0);
        check({tag, "_valid"},   int'(valid),   0);
        check({tag, "_busy"},    int'(busy),    0);
        check({tag, "_ovf"},     int'(ovf),     0);
    endtask

    // A hung simulation still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;

        // 1. reset and idle
        #23;
        check_all_zero("reset");
        rst_n = 1'b1;
        hold(20);
        check_all_zero("idle20");

        // 2. basic measurements
        pulse(1'b1, 1'b0);
        check("run_busy", int'(busy), 1);
        hold(34);
        pulse(1'b0, 1'b1);
        check("s35_result",  int'(result),  3);
        check("s35_valid",   int'(valid),   1);
        check("s35_busy",    int'(busy),    0);
        check("s35_ms_live", int'(ms_live), 3);
        hold(7);
        check("s35_hold_result",  int'(result),  3);
        check("s35_hold_ms_live", int'(ms_live), 3);

        pulse(1'b1, 1'b0);
        hold(29);
        pulse(1'b0, 1'b1);
        check("s30_result", int'(result), 3);

        pulse(1'b1, 1'b0);
        hold(8);
        pulse(1'b0, 1'b1);
        check("s9_result", int'(result), 0);
        check("s9_valid",  int'(valid),  1);

        // 3. simultaneous pulses
        clear = 1'b1;
        hold(1);
        clear = 1'b0;
        pulse(1'b1, 1'b1);
        check("idle_both_busy",  int'(busy),  1);
        check("idle_both_valid", int'(valid), 0);
        hold(7);
        pulse(1'b1, 1'b0);
        check("run_start_busy", int'(busy), 1);
        hold(3);
        pulse(1'b0, 1'b1);
        check("run_start_ignored_result", int'(result), 1);

        pulse(1'b1, 1'b0);
        hold(14);
        pulse(1'b1, 1'b1);
        check("run_both_busy",   int'(busy),   0);
        check("run_both_result", int'(result), 1);
        check("run_both_valid",  int'(valid),  1);

        // 4. overflow
        pulse(1'b1, 1'b0);
        hold(169);
        pulse(1'b0, 1'b1);
        check("ovf_result",  int'(result),  OVF_RESULT);
        check("ovf_ms_live", int'(ms_live), OVF_RESULT);
        check("ovf_flag",    int'(ovf),     1);
        pulse(1'b1, 1'b0);
        check("ovf_cleared", int'(ovf),   0);
        check("ovf_restart", int'(busy),  1);

        // 5. restart from DONE, then clear while running
        hold(29);
        pulse(1'b0, 1'b1);
        check("d_result", int'(result), 3);
        pulse(1'b1, 1'b0);
        check("d_restart_valid",  int'(valid),  0);
        check("d_restart_result", int'(result), 3);
        hold(19);
        pulse(1'b0, 1'b1);
        check("d_s20_result", int'(result), 2);
        check("d_s20_valid",  int'(valid),  1);
        pulse(1'b1, 1'b0);
        hold(15);
        clear = 1'b1;
        hold(1);
        clear = 1'b0;
        check_all_zero("clear_run");

        // 6. asynchronous reset mid-run
        pulse(1'b1, 1'b0);
        hold(25);
        check("pre_rst_ms_live", int'(ms_live), 2);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #2;
        rst_n = 1'b1;
        hold(1);
        pulse(1'b1, 1'b0);
        hold(11);
        pulse(1'b0, 1'b1);
        check("post_rst_result", int'(result), 1);
        check("post_rst_valid",  int'(valid),  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
